// File: rtl/fp_res_pkg.sv
// Shared types and FP32 field constants for the add/sub result collector.
package fp_res_pkg;

    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int SIGN_BIT = 31;

    localparam int CLS_DENORM = 0;
    localparam int CLS_ZERO   = 1;
    localparam int CLS_INF    = 2;
    localparam int CLS_NAN    = 3;

    typedef struct packed {
        logic [31:0] result;
        logic        op;
        logic [3:0]  cls;
        logic        sign;
    } fp_res_entry_t;

    function automatic logic [3:0] fp_classify(input logic [31:0] r);
        logic [EXP_MSB-EXP_LSB:0] e;
        logic [MANT_W-1:0]        m;
        logic [3:0]               c;
        e = r[EXP_MSB:EXP_LSB];
        m = r[MANT_W-1:0];
        c = '0;
        c[CLS_NAN]    = (&e) && (|m);
        c[CLS_INF]    = (&e) && !(|m);
        c[CLS_ZERO]   = !(|e) && !(|m);
        c[CLS_DENORM] = !(|e) && (|m);
        return c;
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous FIFO of collector entries; class/sign storage only exists
// when FP_RES_CLASSIFY_EN is defined.
module fp_res_fifo
    import fp_res_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  fp_res_entry_t din_i,
    output fp_res_entry_t dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [31:0]      res_q [DEPTH];
    logic [DEPTH-1:0] op_q;
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            res_q[wr_q[AW-1:0]] <= din_i.result;
            op_q[wr_q[AW-1:0]]  <= din_i.op;
        end
    end

`ifdef FP_RES_CLASSIFY_EN
    logic [3:0]       cls_q [DEPTH];
    logic [DEPTH-1:0] sign_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            cls_q[wr_q[AW-1:0]]  <= din_i.cls;
            sign_q[wr_q[AW-1:0]] <= din_i.sign;
        end
    end

    always_comb begin
        dout_o = '0;
        if (!empty_o) begin
            dout_o.result = res_q[rd_q[AW-1:0]];
            dout_o.op     = op_q[rd_q[AW-1:0]];
            dout_o.cls    = cls_q[rd_q[AW-1:0]];
            dout_o.sign   = sign_q[rd_q[AW-1:0]];
        end
    end
`else
    logic unused_cls;
    assign unused_cls = ^{din_i.cls, din_i.sign};

    always_comb begin
        dout_o = '0;
        if (!empty_o) begin
            dout_o.result = res_q[rd_q[AW-1:0]];
            dout_o.op     = op_q[rd_q[AW-1:0]];
        end
    end
`endif

endmodule

// File: rtl/fp_result_collector.sv
// Capture stage behind add_sub_main: latency-matched capture, FIFO, status.
// Optional classification/sticky flags enabled by FP_RES_CLASSIFY_EN.
module fp_result_collector
    import fp_res_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic                     issue_op,
    input  logic [WIDTH-1:0]         result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_op,
    output logic [3:0]               out_class,
    output logic                     out_sign,
    output logic                     sticky_nan,
    output logic                     sticky_inf,
    input  logic                     sticky_clr,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] op_q, op_d;
    logic               cap;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;
    fp_res_entry_t      ent;
    fp_res_entry_t      head;
    logic [CNT_W-1:0]   drop_q, drop_d;

    always_comb begin
        vld_d    = vld_q;
        op_d     = op_q;
        vld_d[0] = issue_valid;
        op_d[0]  = issue_op;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            op_d[i]  = op_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            op_q   <= '0;
            drop_q <= '0;
        end else begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            drop_q <= drop_d;
        end
    end

    assign cap  = vld_q[LATENCY-1];
    assign pop  = out_ready && !empty;
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    always_comb begin
        drop_d = drop_q;
        if (drop && !(&drop_q)) drop_d = drop_q + 1'b1;
    end

    always_comb begin
        ent        = '0;
        ent.result = result;
        ent.op     = op_q[LATENCY-1];
`ifdef FP_RES_CLASSIFY_EN
        ent.cls    = fp_classify(result);
        ent.sign   = result[SIGN_BIT];
`endif
    end

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ent),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign out_valid  = !empty;
    assign out_result = head.result;
    assign out_op     = head.op;
    assign drop_cnt   = drop_q;

`ifdef FP_RES_CLASSIFY_EN
    logic nan_q, nan_d;
    logic inf_q, inf_d;

    // A set in the same cycle as a clear takes priority.
    always_comb begin
        nan_d = (nan_q && !sticky_clr) || (cap && ent.cls[CLS_NAN]);
        inf_d = (inf_q && !sticky_clr) || (cap && ent.cls[CLS_INF]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nan_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
            inf_q <= inf_d;
        end
    end

    assign out_class  = head.cls;
    assign out_sign   = head.sign;
    assign sticky_nan = nan_q;
    assign sticky_inf = inf_q;
`else
    logic unused_clr;
    assign unused_clr = ^{sticky_clr, head.cls, head.sign};

    assign out_class  = 4'b0;
    assign out_sign   = 1'b0;
    assign sticky_nan = 1'b0;
    assign sticky_inf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed self-checking bench for fp_result_collector (LATENCY=1, DEPTH=4).
module tb_fp_result_collector;

`ifdef FP_RES_CLASSIFY_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_op;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_op;
    logic [3:0]  out_class;
    logic        out_sign;
    logic        sticky_nan;
    logic        sticky_inf;
    logic        sticky_clr;
    logic [7:0]  drop_cnt;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fp_result_collector #(
        .WIDTH   (32),
        .LATENCY (1),
        .DEPTH   (4),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .out_class   (out_class),
        .out_sign    (out_sign),
        .sticky_nan  (sticky_nan),
        .sticky_inf  (sticky_inf),
        .sticky_clr  (sticky_clr),
        .drop_cnt    (drop_cnt),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle; return 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic op, input logic [31:0] r);
        issue_valid = iv;
        issue_op    = op;
        result      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = 1'b0;
        result      = '0;
        out_ready   = 1'b0;
        sticky_clr  = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_result", out_result, 0);
        chk("rst_sticky", 32'({sticky_nan, sticky_inf}), 0);

        // single add
        cyc(1, 1, 0);
        cyc(0, 0, 32'h4040_0000);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_result", out_result, 32'h4040_0000);
        chk("add_op", 32'(out_op), 1);
        chk("add_class", 32'(out_class), 0);
        chk("add_sign", 32'(out_sign), 0);
        chk("add_count", 32'(count), 1);
        out_ready = 1'b1;
        cyc(0, 0, 0);
        out_ready = 1'b0;
        chk("add_pop_count", 32'(count), 0);
        chk("add_pop_valid", 32'(out_valid), 0);
        chk("empty_result", out_result, 0);

        // NaN and sticky priority
        cyc(1, 0, 0);
        cyc(0, 0, 32'h7FC0_0000);
        chk("nan_class", 32'(out_class), CE ? 32'h8 : 32'h0);
        chk("nan_op", 32'(out_op), 0);
        chk("nan_sticky", 32'(sticky_nan), 32'(CE));
        cyc(1, 0, 0);
        sticky_clr = 1'b1;
        cyc(0, 0, 32'h7FC0_0000);
        sticky_clr = 1'b0;
        chk("nan_set_wins", 32'(sticky_nan), 32'(CE));
        chk("nan_count", 32'(count), 2);
        sticky_clr = 1'b1;
        cyc(0, 0, 0);
        sticky_clr = 1'b0;
        chk("nan_cleared", 32'(sticky_nan), 0);
        out_ready = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        out_ready = 1'b0;
        chk("nan_drain", 32'(count), 0);

        // backpressure: six captures into four entries
        cyc(1, 1, 0);
        for (int k = 1; k <= 5; k++) cyc(1, 1, 32'(k));
        cyc(0, 0, 6);
        chk("bp_count", 32'(count), 4);
        chk("bp_drop", 32'(drop_cnt), 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
            chk($sformatf("bp_order%0d", k), out_result, 32'(k));
            chk($sformatf("bp_class%0d", k), 32'(out_class),
                CE ? 32'h1 : 32'h0);
            cyc(0, 0, 0);
        end
        out_ready = 1'b0;
        chk("bp_empty", 32'(out_valid), 0);
        chk("bp_count0", 32'(count), 0);

        // full FIFO with simultaneous pop and capture
        cyc(1, 1, 0);
        cyc(1, 1, 11);
        cyc(1, 1, 12);
        cyc(1, 1, 13);
        cyc(0, 0, 14);
        chk("fp_full_count", 32'(count), 4);
        cyc(1, 0, 0);
        out_ready = 1'b1;
        cyc(0, 0, 15);
        chk("fp_drop", 32'(drop_cnt), 2);
        chk("fp_count", 32'(count), 4);
        for (int k = 12; k <= 15; k++) begin
            chk($sformatf("fp_order%0d", k), out_result, 32'(k));
            cyc(0, 0, 0);
        end
        out_ready = 1'b0;
        chk("fp_empty", 32'(out_valid), 0);

        // reset while an operation is in flight
        issue_valid = 1'b1;
        issue_op    = 1'b1;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 32'h3F80_0000);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rf_valid", 32'(out_valid), 0);
        chk("rf_count", 32'(count), 0);
        chk("rf_drop", 32'(drop_cnt), 0);
        chk("rf_result", out_result, 0);
        chk("rf_sticky", 32'({sticky_nan, sticky_inf}), 0);

        // remaining classes
        out_ready = 1'b1;
        cyc(1, 0, 0);
        out_ready = 1'b0;
        cyc(0, 0, 32'h8000_0000);
        chk("zero_class", 32'(out_class), CE ? 32'h2 : 32'h0);
        chk("zero_sign", 32'(out_sign), 32'(CE));
        out_ready = 1'b1;
        cyc(1, 1, 0);
        out_ready = 1'b0;
        cyc(0, 0, 32'h0000_0001);
        chk("denorm_class", 32'(out_class), CE ? 32'h1 : 32'h0);
        chk("denorm_sign", 32'(out_sign), 0);
        chk("denorm_op", 32'(out_op), 1);
        chk("pre_inf_sticky", 32'(sticky_inf), 0);
        out_ready = 1'b1;
        cyc(1, 0, 0);
        out_ready = 1'b0;
        cyc(0, 0, 32'hFF80_0000);
        chk("inf_class", 32'(out_class), CE ? 32'h4 : 32'h0);
        chk("inf_sign", 32'(out_sign), 32'(CE));
        chk("inf_sticky", 32'(sticky_inf), 32'(CE));
        chk("inf_no_nan", 32'(sticky_nan), 0);
        chk("inf_count", 32'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
# fp_result_collector

Downstream capture stage for the FP32 add/sub unit (`add_sub_main`). It tracks which cycles carried a real operation through `add_sub_main`'s fixed latency and samples `result` at the matching cycle. Each captured result is tagged with its operation and IEEE-754 class. The entry is then buffered in a small FIFO with a valid/ready output so the consumer can apply backpressure. Sticky exception flags and a dropped-result counter are kept for status reporting.

## Interface
- WIDTH, 32: result width; only 32 (FP32 field positions) supported.
- LATENCY, 1: cycles from operands applied to `add_sub_main` until its `result` is valid; legal 1..8.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, 8: width of `drop_cnt`.

Ports:
- clk  in  1  rising-edge clock, shared with `add_sub_main`.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  operands on `add_sub_main` inputs this cycle form a real operation.
- issue_op  in  1  `operation_select` for that operation (1 = add, 0 = sub).
- result  in  WIDTH  `add_sub_main` result.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_result  out  WIDTH  head result.
- out_op  out  1  head operation tag.
- out_class  out  4  head class {nan, inf, zero, denorm}, bit 3 = nan.
- out_sign  out  1  head result bit 31.
- sticky_nan  out  1  a NaN result has been captured since reset or clear.
- sticky_inf  out  1  an infinity result has been captured since reset or clear.
- sticky_clr  in  1  clear both sticky flags.
- drop_cnt  out  CNT_W  results lost because the FIFO was full; saturates at all-ones.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Delay line: LATENCY-stage shift register of {valid, op}. Stage 0 loads {`issue_valid`, `issue_op`} each cycle.
- Capture: when the last stage is valid, `result` is sampled that cycle and an entry is formed.
- Entry fields: {result, op, class, sign}.
- Classification (exp = bits 30:23, mant = bits 22:0):
  - nan: exp = 0xFF, mant ≠ 0.
  - inf: exp = 0xFF, mant = 0.
  - zero: exp = 0, mant = 0.
  - denorm: exp = 0, mant ≠ 0.
  - Exactly one or no class bit is set.
- Push: a capture pushes into the FIFO unless the FIFO is full and no pop happens the same cycle. Full with simultaneous pop: push accepted, occupancy unchanged.
- Drop: a capture refused by a full FIFO increments `drop_cnt`, saturating. FIFO contents are unchanged.
- Pop: occurs when `out_valid` and `out_ready` are both high. Order is strictly FIFO.
- Empty FIFO: `out_valid`=0 and all `out_*` data outputs are driven 0. With `out_valid`=0, `out_ready` is ignored.
- Sticky flags:
  - Set on every capture with nan/inf class, including dropped captures.
  - `sticky_clr` clears both flags.
  - A set in the same cycle as a clear wins.

## Timing
- Reset values: all outputs 0 and delay line cleared. Operations in flight at reset are never captured, even if their `result` arrives after reset releases.
- Latency: `issue_valid` in cycle t → capture in cycle t+LATENCY → `out_valid` high in cycle t+LATENCY+1 at the earliest.
- Throughput: one capture and one pop per cycle, sustained.
- `count` is registered and reflects pushes and pops from the previous edge.
- Output data comes from registered FIFO storage; there is no combinational path from `result` to `out_*`.
- `out_valid` does not depend on `out_ready`. Once `out_valid` is asserted, the head entry is held stable until it is popped.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

## Configuration
- FP_RES_CLASSIFY_EN defined: classification logic, `out_class`/`out_sign` storage and sticky flags are present, as described above.
- FP_RES_CLASSIFY_EN undefined:
  - Classification logic and the class/sign FIFO storage are removed.
  - `out_class`, `out_sign`, `sticky_nan` and `sticky_inf` are tied to 0.
  - `sticky_clr` is ignored.
  - Port list is unchanged.

## Structure
- Package `fp_res_pkg`:
  - FP32 field constants (EXP_MSB=30, EXP_LSB=23, MANT_W=23, SIGN_BIT=31).
  - Class bit indices.
  - `fp_res_entry_t` packed struct {result, op, class, sign}.
- Sub-module `fp_res_fifo`: parameterized synchronous FIFO of `fp_res_entry_t` with push/pop, full/empty and count. The top level holds the delay line, classifier, sticky flags and drop counter.

## Test plan
All scenarios use LATENCY=1, DEPTH=4.
- Single add: `issue_valid`=1 with op=1, then `result`=0x40400000 next cycle → following cycle `out_valid`=1, `out_result`=0x40400000, `out_op`=1, `out_class`=0000, `out_sign`=0, `count`=1.
- NaN: capture 0x7FC00000 → `out_class`=1000 and `sticky_nan`=1. Capture 0x7FC00000 again with `sticky_clr`=1 the same cycle → `sticky_nan` stays 1. Pulse `sticky_clr` alone → 0.
- Backpressure: `out_ready`=0, six back-to-back issues with results 1..6 → `count`=4, `drop_cnt`=2. Then `out_ready`=1 → pops 1, 2, 3, 4 in order, then `out_valid`=0.
- Full with pop: FIFO full, `out_ready`=1, one capture → `drop_cnt` unchanged, `count` stays 4.
- Reset mid-flight: issue in cycle t, `rst_n`=0 in cycle t, result 0x3F800000 in t+1 → no entry is ever produced and all outputs are 0.
- Classes: 0x80000000 → zero, sign=1. 0x00000001 → denorm. 0xFF800000 → inf, `sticky_inf`=1. Build without FP_RES_CLASSIFY_EN → class, sign and sticky outputs remain 0.
